// File: rtl/alu_pkg.sv
// Shared definitions for the alu datapath and its command engine: op codes,
// flag bit positions and the engine FSM state encoding.
package alu_pkg;

  // Op codes carried on cmd_op and decoded by the alu.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  // Bit positions inside the 4-bit flags vector {ovf, carry, zero, neg}.
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_NEG   = 0;

  // Engine sequencing: one command in flight at a time.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage : alu_pkg

// File: rtl/alu.sv
// Combinational alu: add/sub/logic/shift on WIDTH-bit operands with
// {overflow, carry, zero, negative} flags. Shift amounts >= WIDTH saturate
// to WIDTH-1.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  localparam int SHW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MAX_SH = WIDTH'(WIDTH - 1);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic             carry;
  logic             ovf;

  // Compute the result and the op-dependent carry/overflow flags.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    y     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    shamt = (b > MAX_SH) ? MAX_SH[SHW-1:0] : b[SHW-1:0];
    case (op)
      OP_ADD: begin
        y     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // The borrow out of the zero-extended subtraction is set exactly when A < B unsigned.
        y     = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << shamt;
      OP_SRL:  y = a >> shamt;
      OP_SRA:  y = $unsigned($signed(a) >>> shamt);
      default: y = '0;
    endcase
  end

  // Assemble the flags vector from the result and the arithmetic side flags.
  always_comb begin
    flags             = '0;
    flags[FLAG_OVF]   = ovf;
    flags[FLAG_CARRY] = carry;
    flags[FLAG_ZERO]  = (y == '0);
    flags[FLAG_NEG]   = y[WIDTH-1];
  end

endmodule : alu

// File: rtl/alu_cmd_engine.sv
// Command engine in front of the alu: accepts op commands over valid/ready,
// reads operands from a 4-entry register file (or an immediate), executes,
// writes the result back and returns result+flags over valid/ready.
// Optional feature macro: ALU_STICKY_FLAGS_EN adds sticky_clr / sticky_flags,
// accumulating {ovf, carry} across completed operations.
module alu_cmd_engine
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_rs1,
  input  logic [1:0]       cmd_rs2,
  input  logic             cmd_imm_sel,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic [3:0]       rsp_flags,
  input  logic [1:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
`ifdef ALU_STICKY_FLAGS_EN
  ,
  input  logic             sticky_clr,
  output logic [1:0]       sticky_flags
`endif
);

  state_t           state;
  logic [2:0]       op_q;
  logic [1:0]       rd_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rf [4];
  logic [WIDTH-1:0] alu_y;
  logic [3:0]       alu_flags;

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .y     (alu_y),
    .flags (alu_flags)
  );

  assign dbg_data = rf[dbg_addr];

  // Sequencer: latch operands, execute + write back, then hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_flags <= '0;
      op_q      <= OP_ADD;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      // NOTE: this register file is architecturally zero after reset, so it
      // is cleared here; larger memories are normally left unreset.
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      // NOTE: all state updates are non-blocking, so every register samples
      // the pre-edge values (operands read in IDLE see the old rf contents).
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            rd_q      <= cmd_rd;
            a_q       <= rf[cmd_rs1];
            b_q       <= cmd_imm_sel ? cmd_imm : rf[cmd_rs2];
            cmd_ready <= 1'b0;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_y     <= alu_y;
          rsp_flags <= alu_flags;
          rf[rd_q]  <= alu_y;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_STICKY_FLAGS_EN
  logic [1:0] sticky_set;
  assign sticky_set = (state == ST_EXEC) ? {alu_flags[FLAG_OVF], alu_flags[FLAG_CARRY]} : 2'b00;

  // Accumulate {ovf, carry}; a set in the same cycle as a clear still lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= 2'b00;
    end else begin
      sticky_flags <= (sticky_clr ? 2'b00 : sticky_flags) | sticky_set;
    end
  end
`endif

endmodule : alu_cmd_engine

// File: tb/tb_alu_cmd_engine.sv
// Directed, table-driven bench for alu_cmd_engine (WIDTH=32), plus hand
// sequences for backpressure, reset mid-command and (optionally) sticky flags.
module tb_alu_cmd_engine;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [1:0]       cmd_rd;
  logic [1:0]       cmd_rs1;
  logic [1:0]       cmd_rs2;
  logic             cmd_imm_sel;
  logic [WIDTH-1:0] cmd_imm;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic [3:0]       rsp_flags;
  logic [1:0]       dbg_addr;
  logic [WIDTH-1:0] dbg_data;
`ifdef ALU_STICKY_FLAGS_EN
  logic             sticky_clr;
  logic [1:0]       sticky_flags;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0]       op;
    logic [1:0]       rd;
    logic [1:0]       rs1;
    logic [1:0]       rs2;
    logic             imm_sel;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] exp_y;
    logic [3:0]       exp_flags;
  } vec_t;

  vec_t             vecs [14];
  logic [WIDTH-1:0] model_rf [4];

  alu_cmd_engine #(
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rd      (cmd_rd),
    .cmd_rs1     (cmd_rs1),
    .cmd_rs2     (cmd_rs2),
    .cmd_imm_sel (cmd_imm_sel),
    .cmd_imm     (cmd_imm),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_y       (rsp_y),
    .rsp_flags   (rsp_flags),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`ifdef ALU_STICKY_FLAGS_EN
    ,
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every register-file entry against the bench model via the debug port.
  task automatic check_rf(input string name);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check($sformatf("%s_rf%0d", name, i), 64'(dbg_data), 64'(model_rf[i]));
    end
  endtask

  // Drive a command at a falling edge; it is accepted at the next rising edge.
  task automatic drive_cmd(input vec_t v);
    cmd_op      = v.op;
    cmd_rd      = v.rd;
    cmd_rs1     = v.rs1;
    cmd_rs2     = v.rs2;
    cmd_imm_sel = v.imm_sel;
    cmd_imm     = v.imm;
    cmd_valid   = 1'b1;
  endtask

  // Full transaction with latency, result, handshake and write-back checks.
  task automatic run_cmd(input string name, input vec_t v);
    @(negedge clk);
    check({name, "_ready"}, 64'(cmd_ready), 64'd1);
    drive_cmd(v);
    @(negedge clk);                       // one edge after accept: EXEC
    cmd_valid = 1'b0;
    check({name, "_early"}, 64'(rsp_valid), 64'd0);
    check({name, "_busy"}, 64'(cmd_ready), 64'd0);
    @(negedge clk);                       // two edges after accept: RESP
    check({name, "_valid"}, 64'(rsp_valid), 64'd1);
    check({name, "_y"}, 64'(rsp_y), 64'(v.exp_y));
    check({name, "_flags"}, 64'(rsp_flags), 64'(v.exp_flags));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "_done"}, 64'(rsp_valid), 64'd0);
    model_rf[v.rd] = v.exp_y;
    check_rf(name);
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                              input logic [1:0] rs2, input logic imm_sel, input logic [WIDTH-1:0] imm,
                              input logic [WIDTH-1:0] exp_y, input logic [3:0] exp_flags);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm_sel = imm_sel;
    v.imm = imm; v.exp_y = exp_y; v.exp_flags = exp_flags;
    return v;
  endfunction

  // Watchdog: the bench never waits on DUT events unboundedly, but cap the run anyway.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    // op     rd  rs1 rs2 imm  imm           exp_y         flags {ovf,carry,zero,neg}
    vecs[0]  = mk(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 32'h0000_0005, 32'h0000_0005, 4'b0000); // ADD 0+5
    vecs[1]  = mk(3'b001, 2'd2, 2'd1, 2'd0, 1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 4'b0101); // SUB 5-6
    vecs[2]  = mk(3'b000, 2'd3, 2'd0, 2'd0, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0000); // ADD 0+7FFFFFFF
    vecs[3]  = mk(3'b000, 2'd0, 2'd3, 2'd0, 1'b1, 32'h0000_0001, 32'h8000_0000, 4'b1001); // ADD ovf
    vecs[4]  = mk(3'b000, 2'd1, 2'd2, 2'd0, 1'b1, 32'h0000_0001, 32'h0000_0000, 4'b0110); // ADD carry, zero
    vecs[5]  = mk(3'b001, 2'd1, 2'd1, 2'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0100); // SUB 0-FFFFFFFF borrow
    vecs[6]  = mk(3'b101, 2'd3, 2'd1, 2'd0, 1'b1, 32'd40,        32'h8000_0000, 4'b0001); // SLL 1<<40 sat
    vecs[7]  = mk(3'b111, 2'd2, 2'd3, 2'd0, 1'b1, 32'd33,        32'hFFFF_FFFF, 4'b0001); // SRA sat, sign-fill
    vecs[8]  = mk(3'b110, 2'd3, 2'd3, 2'd0, 1'b1, 32'd4,         32'h0800_0000, 4'b0000); // SRL, rd==rs1
    vecs[9]  = mk(3'b010, 2'd0, 2'd2, 2'd3, 1'b0, 32'hDEAD_BEEF, 32'h0800_0000, 4'b0000); // AND regs
    vecs[10] = mk(3'b011, 2'd1, 2'd1, 2'd0, 1'b0, 32'h0000_0000, 32'h0800_0001, 4'b0000); // OR regs
    vecs[11] = mk(3'b100, 2'd2, 2'd2, 2'd2, 1'b0, 32'h1234_5678, 32'h0000_0000, 4'b0010); // XOR self
    vecs[12] = mk(3'b001, 2'd3, 2'd0, 2'd0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0010); // SUB equal
    vecs[13] = mk(3'b001, 2'd3, 2'd2, 2'd0, 1'b1, 32'h8000_0000, 32'h8000_0000, 4'b1101); // SUB ovf+borrow

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; dbg_addr = 2'd0;
    cmd_op = 3'b000; cmd_rd = 2'd0; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0;
    cmd_imm_sel = 1'b0; cmd_imm = '0;
`ifdef ALU_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    for (int i = 0; i < 4; i++) model_rf[i] = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_y", 64'(rsp_y), 64'd0);
    check("rst_rsp_flags", 64'(rsp_flags), 64'd0);
    check_rf("rst");
`ifdef ALU_STICKY_FLAGS_EN
    check("rst_sticky", 64'(sticky_flags), 64'd0);
`endif

    // Main vector table.
    for (int i = 0; i < 14; i++) run_cmd($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: response held stable and new commands ignored.
    // rf now: 0=08000000 1=08000001 2=0 3=80000000
    v = mk(3'b000, 2'd2, 2'd1, 2'd0, 1'b1, 32'h0000_0001, 32'h0800_0002, 4'b0000);
    @(negedge clk);
    drive_cmd(v);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("hold_valid0", 64'(rsp_valid), 64'd1);
    drive_cmd(mk(3'b100, 2'd3, 2'd0, 2'd0, 1'b1, 32'h0000_FFFF, 32'h0, 4'h0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold_valid_c%0d", i), 64'(rsp_valid), 64'd1);
      check($sformatf("hold_y_c%0d", i), 64'(rsp_y), 64'h0800_0002);
      check($sformatf("hold_flags_c%0d", i), 64'(rsp_flags), 64'h0);
      check($sformatf("hold_ready_c%0d", i), 64'(cmd_ready), 64'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("hold_release", 64'(rsp_valid), 64'd0);
    model_rf[2] = 32'h0800_0002;
    check_rf("hold");

    // Reset while the response is pending.
    @(negedge clk);
    drive_cmd(mk(3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 32'h0000_0001, 32'h0, 4'h0));
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rresp_pending", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rresp_valid", 64'(rsp_valid), 64'd0);
    check("rresp_ready", 64'(cmd_ready), 64'd1);
    check("rresp_y", 64'(rsp_y), 64'd0);
    check("rresp_flags", 64'(rsp_flags), 64'd0);
    for (int i = 0; i < 4; i++) model_rf[i] = '0;
    check_rf("rresp");

    // Reset during EXEC: the write-back must be dropped.
    @(negedge clk);
    drive_cmd(mk(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 32'h0000_0009, 32'h0, 4'h0));
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rexec_valid", 64'(rsp_valid), 64'd0);
    check("rexec_ready", 64'(cmd_ready), 64'd1);
    check_rf("rexec");
    run_cmd("recover", mk(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 32'h0000_0003, 32'h0000_0003, 4'b0000));

`ifdef ALU_STICKY_FLAGS_EN
    // Sticky flags: carry persists across later ops until cleared.
    run_cmd("stk_a", mk(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001));
    check("stk_none", 64'(sticky_flags), 64'd0);
    run_cmd("stk_b", mk(3'b000, 2'd2, 2'd1, 2'd0, 1'b1, 32'h0000_0002, 32'h0000_0001, 4'b0100));
    check("stk_carry", 64'(sticky_flags), 64'b01);
    run_cmd("stk_c", mk(3'b010, 2'd3, 2'd1, 2'd2, 1'b0, 32'h0, 32'h0000_0001, 4'b0000));
    check("stk_persist", 64'(sticky_flags), 64'b01);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    check("stk_clear", 64'(sticky_flags), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_cmd_engine
